// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, default address width
// and the 3-bit opcode map that decode uses to raise halt / branch_en.
package cpu_pkg;

  localparam int unsigned DEFAULT_PC_BITS = 12;
  localparam int unsigned OPC_BITS        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Opcode map; OP_BRANCH/OP_JUMP drive branch_en, OP_HALT drives halt.
  localparam logic [OPC_BITS-1:0] OP_ALU    = 3'd0;
  localparam logic [OPC_BITS-1:0] OP_ALUI   = 3'd1;
  localparam logic [OPC_BITS-1:0] OP_LOAD   = 3'd2;
  localparam logic [OPC_BITS-1:0] OP_STORE  = 3'd3;
  localparam logic [OPC_BITS-1:0] OP_BRANCH = 3'd4;
  localparam logic [OPC_BITS-1:0] OP_JUMP   = 3'd5;
  localparam logic [OPC_BITS-1:0] OP_NOP    = 3'd6;
  localparam logic [OPC_BITS-1:0] OP_HALT   = 3'd7;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : synchronous clear to zero (wins over en)
//   en         : increment by one unless already all-ones
//   count      : registered count value
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Count register; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the combinational instruction memory.
// Decides every cycle whether pc advances, branches, stalls or stops, and
// reports run status plus a saturating retired-instruction count.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   start           : launch request, honoured in IDLE or DONE only
//   stall           : hold pc; current instruction does not retire
//   halt            : current instruction is a halt; retires, then stop
//   branch_en       : take branch_target as next pc
//   branch_target   : absolute branch destination
//   pc              : registered instruction-memory address
//   running / done  : registered status flags
//   instr_count     : retired instructions since the last start
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned         PC_BITS  = DEFAULT_PC_BITS,
  parameter logic [PC_BITS-1:0]  START_PC = '0,
  parameter int unsigned         CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                halt,
  input  logic                branch_en,
  input  logic [PC_BITS-1:0]  branch_target,
  output logic [PC_BITS-1:0]  pc,
  output logic                running,
  output logic                done,
  output logic [CNT_BITS-1:0] instr_count
);

  localparam logic [PC_BITS-1:0] PC_MAX = '1;

  seq_state_t state;
  logic       cnt_clear;
  logic       cnt_en;

  // A launch clears the count; any non-stalled RUN cycle (or a halt) retires one.
  assign cnt_clear = (state != RUN) && start;
  assign cnt_en    = (state == RUN) && (halt || !stall);

  // State, pc and status flags; priority in RUN is halt > stall > branch > sequential.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            pc      <= START_PC;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          if (halt) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (stall) begin
            state <= RUN;
          end else if (branch_en) begin
            pc <= branch_target;
          end else if (pc != PC_MAX) begin
            pc <= pc + PC_BITS'(1);
          end else begin
            // Runaway guard: last address retires, then stop instead of wrapping.
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_BITS)
  ) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (instr_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a default instance (START_PC=0, 16-bit count)
// and a second one (START_PC=0xFFD, 4-bit count) share the stimulus.
module tb_fetch_sequencer;

  localparam int unsigned    PCW  = 12;
  localparam int unsigned    CW0  = 16;
  localparam int unsigned    CW1  = 4;
  localparam logic [PCW-1:0] SPC1 = 12'hFFD;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  typedef struct {
    int          st;
    logic [11:0] pc;
    int unsigned cnt;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           stall = 1'b0;
  logic           halt = 1'b0;
  logic           branch_en = 1'b0;
  logic [PCW-1:0] branch_target = '0;

  logic [PCW-1:0] pc0, pc1;
  logic           running0, running1, done0, done1;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;

  int   errors = 0;
  int   checks = 0;
  mdl_t m0, m1;
  exp_t sb[$];

  fetch_sequencer dut0 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_target(branch_target),
    .pc(pc0), .running(running0), .done(done0), .instr_count(cnt0)
  );

  fetch_sequencer #(.PC_BITS(PCW), .START_PC(SPC1), .CNT_BITS(CW1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_target(branch_target),
    .pc(pc1), .running(running1), .done(done1), .instr_count(cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one sequencer for one clock edge.
  function automatic mdl_t mnext(input mdl_t m, input logic [11:0] spc, input int unsigned cmax,
                                 input logic s, input logic sl, input logic h,
                                 input logic be, input logic [11:0] bt);
    mdl_t n = m;
    if (m.st != S_RUN) begin
      if (s) begin
        n.st = S_RUN; n.pc = spc; n.cnt = 0;
      end
    end else if (h) begin
      n.st = S_DONE;
      if (m.cnt < cmax) n.cnt = m.cnt + 1;
    end else if (!sl) begin
      if (m.cnt < cmax) n.cnt = m.cnt + 1;
      if (be) n.pc = bt;
      else if (m.pc == 12'hFFF) n.st = S_DONE;
      else n.pc = m.pc + 12'd1;
    end
    return n;
  endfunction

  task automatic model_reset();
    m0.st = S_IDLE; m0.pc = '0; m0.cnt = 0;
    m1.st = S_IDLE; m1.pc = '0; m1.cnt = 0;
  endtask

  task automatic compare_all(input exp_t e);
    chk("pc0",   32'(pc0),      32'(e.a.pc));
    chk("run0",  32'(running0), (e.a.st == S_RUN)  ? 32'd1 : 32'd0);
    chk("done0", 32'(done0),    (e.a.st == S_DONE) ? 32'd1 : 32'd0);
    chk("cnt0",  32'(cnt0),     32'(e.a.cnt));
    chk("pc1",   32'(pc1),      32'(e.b.pc));
    chk("run1",  32'(running1), (e.b.st == S_RUN)  ? 32'd1 : 32'd0);
    chk("done1", 32'(done1),    (e.b.st == S_DONE) ? 32'd1 : 32'd0);
    chk("cnt1",  32'(cnt1),     32'(e.b.cnt));
  endtask

  // Drive one cycle of inputs, predict, then compare one step after the edge.
  task automatic step(input logic s, input logic sl, input logic h,
                      input logic be, input logic [PCW-1:0] bt);
    exp_t e;
    @(negedge clk);
    start = s; stall = sl; halt = h; branch_en = be; branch_target = bt;
    m0 = mnext(m0, 12'h000, 32'hFFFF, s, sl, h, be, bt);
    m1 = mnext(m1, SPC1, 32'd15, s, sl, h, be, bt);
    e.a = m0; e.b = m1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      compare_all(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc0", 32'(pc0), 32'd0);
    chk("rst_run0", 32'(running0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_pc1", 32'(pc1), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential run to pc=5 then halt; dut1 runs off the top of memory.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t1_start_pc1", 32'(pc1), 32'hFFD);
    idle(5);
    chk("t1_pc5", 32'(pc0), 32'd5);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("t1_done0", 32'(done0), 32'd1);
    chk("t1_hold_pc0", 32'(pc0), 32'd5);
    chk("t1_cnt0", 32'(cnt0), 32'd6);
    chk("t1_guard_pc1", 32'(pc1), 32'hFFF);
    chk("t1_guard_done1", 32'(done1), 32'd1);
    chk("t1_guard_cnt1", 32'(cnt1), 32'd3);
    idle(2);
    chk("t1_still_pc0", 32'(pc0), 32'd5);

    // Restart from DONE, then branch at pc=2.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t4_restart_pc1", 32'(pc1), 32'hFFD);
    chk("t4_restart_done1", 32'(done1), 32'd0);
    chk("t4_restart_cnt1", 32'(cnt1), 32'd0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h040);
    chk("t2_br_pc0", 32'(pc0), 32'h040);
    chk("t2_br_cnt0", 32'(cnt0), 32'd3);
    idle(1);
    chk("t2_seq_pc0", 32'(pc0), 32'h041);
    chk("t2_seq_cnt0", 32'(cnt0), 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Stall with a pending branch at pc=3.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 12'h100);
      chk("t3_stall_pc0", 32'(pc0), 32'd3);
      chk("t3_stall_cnt0", 32'(cnt0), 32'd3);
    end
    idle(1);
    chk("t3_after_pc0", 32'(pc0), 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Self-loop on dut1's start pc saturates its 4-bit count.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, SPC1);
    chk("t5_sat_cnt1", 32'(cnt1), 32'd15);
    chk("t5_loop_pc1", 32'(pc1), 32'hFFD);
    chk("t5_cnt0", 32'(cnt0), 32'd20);

    // Asynchronous reset between clock edges while running.
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_pc0", 32'(pc0), 32'd0);
    chk("t6_async_run0", 32'(running0), 32'd0);
    chk("t6_async_cnt0", 32'(cnt0), 32'd0);
    chk("t6_async_pc1", 32'(pc1), 32'd0);
    chk("t6_async_run1", 32'(running1), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    chk("t6_rerun_pc0", 32'(pc0), 32'd1);
    chk("t6_rerun_pc1", 32'(pc1), 32'hFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
